instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
Instruction-fetch stage between the PC register and decode. Takes the current PC, issues word-aligned requests on the instruction-memory req/gnt/rvalid bus, and tags each returned word with its PC. Tagged words go into a small prefetch FIFO that feeds decode through a valid/ready handshake. It pulses the PC-register write enable when a request is granted, and discards stale data on a branch/trap flush.

Parameters:
DEPTH, 2, prefetch FIFO entries; power of two, minimum 2
AW, 32, address/PC width
DW, 32, instruction word width

Ports:
i_clk  in  1  clock
i_resetn  in  1  asynchronous active-low reset
i_pc  in  AW  current PC from the PC register
o_pc_we  out  1  pulse: request granted, PC register may advance
i_flush  in  1  branch/trap redirect; discard everything in flight
o_imem_req  out  1  instruction-memory request
o_imem_addr  out  AW  request address, {i_pc[AW-1:2],2'b00}
i_imem_gnt  in  1  request accepted this cycle
i_imem_rvalid  in  1  read data valid
i_imem_rdata  in  DW  read data
o_instr_valid  out  1  FIFO head valid
i_instr_ready  in  1  decode accepts head
o_instr  out  DW  head instruction
o_instr_pc  out  AW  head PC

Behaviour:
- Clock and reset: single clock i_clk. Reset i_resetn is asynchronous and active-low. All state is cleared on assertion.
- Reset values: o_imem_req=0, o_pc_we=0, o_instr_valid=0, o_instr=0, o_instr_pc=0, FIFO empty, FSM=IDLE.
- At most one outstanding request.
- An address/PC capture register holds o_imem_addr for the whole request.
- FSM states:
  - IDLE: if !i_flush and (count + 0) < DEPTH, capture i_pc, go REQ.
  - REQ: o_imem_req=1 and o_imem_addr stable until i_imem_gnt. On gnt, o_pc_we=1 for exactly that cycle and go WAIT.
  - WAIT: on i_imem_rvalid, push {captured PC, rdata} into the FIFO. Then go REQ if space remains after the push, else IDLE. REQ captures the new i_pc in the same cycle.
  - DRAIN: the response of a flushed request is still pending. Drop the next rvalid (no push), then go IDLE.
- Space check: request only when FIFO count + 1 (the outstanding slot) <= DEPTH. A granted response therefore always has a free slot.
- Flush:
  - Same-cycle effects: FIFO emptied, o_instr_valid=0 next cycle, o_pc_we forced 0.
  - In REQ without gnt: drop the request next cycle, go IDLE.
  - In REQ with gnt, or in WAIT without rvalid: go DRAIN.
  - In WAIT with rvalid: drop the data, go IDLE.
  - The new PC is taken from i_pc on the first IDLE->REQ after the flush. Redirect ordering is the PC register's responsibility.
- FIFO: circular, pointers of log2(DEPTH) bits, plus a count of log2(DEPTH)+1 bits. Wrap is modulo DEPTH.
  - Push and pop in the same cycle: count unchanged.
  - Pop when empty is ignored.
  - Push when full is impossible by construction; an assertion fires in simulation.
- Decode handshake: o_instr/o_instr_pc are registered from the head entry. Values hold while o_instr_valid && !i_instr_ready. A pop occurs on valid && ready.
- Latency: grant to rvalid is at least 1 cycle (bus rule). Data written on rvalid at edge N is visible on o_instr_valid at N+1.
- Mid-request reset: everything clears asynchronously. The memory side is expected to be reset by the same i_resetn.

Optional Feature:
FETCH_ERR_EN
- Adds input i_imem_err (qualified by rvalid) and output o_instr_err (1 bit).
- With the macro defined: the error bit is stored per FIFO entry and presented with o_instr. An erroring entry is delivered normally; decode raises an instruction-access fault.
- Without it: no port, no storage; the bus error is ignored.

Decomposition:
- Shared package: FSM state encoding (IDLE/REQ/WAIT/DRAIN), the fetch entry typedef {pc, instr[, err]}, and the word-alignment mask constant.
- One natural sub-module: fetch_fifo (parameterised DEPTH and entry width, push/pop/flush/count). Its width is set by FETCH_ERR_EN.

Test Plan:
1. Reset, i_pc=0x80, gnt same cycle, rvalid one cycle later with 0x00000013, ready=1:
   - o_imem_addr=0x80
   - o_pc_we single pulse
   - o_instr=0x13, o_instr_pc=0x80 one cycle after rvalid
2. ready=0, PCs 0x80/0x84 fetched with DEPTH=2:
   - FIFO fills; o_imem_req stays 0 after the second grant
   - ready=1 for one cycle -> one pop, and a new request for 0x88 issues
3. gnt held low 5 cycles:
   - o_imem_req and o_imem_addr=0x84 stable throughout
   - o_pc_we stays 0 until gnt
4. Flush while in WAIT, then rvalid with 0xDEADBEEF:
   - word dropped, FIFO empty, o_instr_valid=0
   - next request uses the new i_pc=0x200
5. Flush and rvalid in the same cycle, plus a simultaneous pop/push with FIFO count=1:
   - flushed data is not pushed
   - in the separate pop/push case, count stays 1 and the pointer wrap is correct across 8 iterations
6. With FETCH_ERR_EN, rvalid with i_imem_err=1 at PC 0x90:
   - o_instr_err=1 with o_instr_pc=0x90
   - the following entry has err=0

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encoding and word-alignment constants.
// The optional per-entry bus-error bit is enabled by FETCH_ERR_EN in instr_fetch.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  // Low address bits cleared to form a word-aligned fetch address.
  localparam int unsigned WORD_OFS_BITS = 2;

endpackage

// File: rtl/fetch_fifo.sv
// Circular DEPTH-entry FIFO; head is read straight from storage, so a push is visible next cycle.
// No internal backpressure: caller guarantees space before pushing; flush empties it in one cycle.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [W-1:0]           push_dat_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic                   head_vld_o,
  output logic [W-1:0]           head_dat_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW:0]   count_q;
  logic          do_pop;

  // Popping an empty FIFO is a no-op.
  assign do_pop     = pop_i && (count_q != '0);
  assign head_vld_o = (count_q != '0);
  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_i && !do_pop)      count_q <= count_q + 1'b1;
      else if (!push_i && do_pop) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && push_i && !flush_i)
      assert (count_q != FULL_CNT) else $error("fetch_fifo: push while full");
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: one outstanding imem request, returned words tagged with PC into a prefetch FIFO.
// Word reaches decode the cycle after rvalid; requests stall when no FIFO slot is free. FETCH_ERR_EN adds err.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          i_clk,
  input  logic          i_resetn,
  input  logic [AW-1:0] i_pc,
  output logic          o_pc_we,
  input  logic          i_flush,
  output logic          o_imem_req,
  output logic [AW-1:0] o_imem_addr,
  input  logic          i_imem_gnt,
  input  logic          i_imem_rvalid,
  input  logic [DW-1:0] i_imem_rdata,
`ifdef FETCH_ERR_EN
  input  logic          i_imem_err,
  output logic          o_instr_err,
`endif
  output logic          o_instr_valid,
  input  logic          i_instr_ready,
  output logic [DW-1:0] o_instr,
  output logic [AW-1:0] o_instr_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] DEPTH_M1  = CW'(DEPTH - 1);
  localparam logic [AW-1:0] ALIGN_MSK = {AW{1'b1}} << WORD_OFS_BITS;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
`ifdef FETCH_ERR_EN
    logic          err;
`endif
  } fetch_entry_t;

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  fetch_entry_t  push_ent, head_ent;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_push, fifo_pop, head_vld, space_after_push;

  assign o_imem_addr = addr_q & ALIGN_MSK;
  assign fifo_pop    = head_vld && i_instr_ready;
  // The outstanding slot is reserved, so a pop or one spare entry leaves room for the next request.
  assign space_after_push = fifo_pop || (fifo_cnt < DEPTH_M1);

  always_comb begin
    push_ent       = '0;
    push_ent.pc    = o_imem_addr;
    push_ent.instr = i_imem_rdata;
`ifdef FETCH_ERR_EN
    push_ent.err   = i_imem_err;
`endif
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    fifo_push  = 1'b0;
    o_pc_we    = 1'b0;
    o_imem_req = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!i_flush && (fifo_cnt < DEPTH_C)) begin
          addr_d  = i_pc;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        o_imem_req = 1'b1;
        if (i_imem_gnt) begin
          o_pc_we = !i_flush;
          state_d = i_flush ? ST_DRAIN : ST_WAIT;
        end else if (i_flush) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (i_imem_rvalid) begin
          if (i_flush) begin
            state_d = ST_IDLE;
          end else begin
            fifo_push = 1'b1;
            if (space_after_push) begin
              addr_d  = i_pc;
              state_d = ST_REQ;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end else if (i_flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (i_imem_rvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(fetch_entry_t))
  ) u_fifo (
    .clk_i      (i_clk),
    .rst_ni     (i_resetn),
    .push_i     (fifo_push),
    .push_dat_i (push_ent),
    .pop_i      (fifo_pop),
    .flush_i    (i_flush),
    .head_vld_o (head_vld),
    .head_dat_o (head_ent),
    .count_o    (fifo_cnt)
  );

  assign o_instr_valid = head_vld;
  assign o_instr       = head_ent.instr;
  assign o_instr_pc    = head_ent.pc;
`ifdef FETCH_ERR_EN
  assign o_instr_err   = head_ent.err;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch (DEPTH=2): reset, fetch, stall, flush, FIFO wrap; FETCH_ERR_EN case when defined.
module tb_instr_fetch;

  logic        i_clk;
  logic        i_resetn;
  logic [31:0] i_pc;
  logic        o_pc_we;
  logic        i_flush;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        o_instr_valid;
  logic        i_instr_ready;
  logic [31:0] o_instr;
  logic [31:0] o_instr_pc;
`ifdef FETCH_ERR_EN
  logic        i_imem_err;
  logic        o_instr_err;
`endif

  int n_vec = 0;
  int n_err = 0;

  instr_fetch #(.DEPTH(2), .AW(32), .DW(32)) dut (
    .i_clk         (i_clk),
    .i_resetn      (i_resetn),
    .i_pc          (i_pc),
    .o_pc_we       (o_pc_we),
    .i_flush       (i_flush),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
`ifdef FETCH_ERR_EN
    .i_imem_err    (i_imem_err),
    .o_instr_err   (o_instr_err),
`endif
    .o_instr_valid (o_instr_valid),
    .i_instr_ready (i_instr_ready),
    .o_instr       (o_instr),
    .o_instr_pc    (o_instr_pc)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic reset_dut(input logic [31:0] pc);
    i_resetn      = 1'b0;
    i_flush       = 1'b0;
    i_imem_gnt    = 1'b0;
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = '0;
    i_instr_ready = 1'b0;
    i_pc          = pc;
    cyc();
    cyc();
    i_resetn = 1'b1;
  endtask

  // From REQ: grant now, return data the next cycle; PC register advances to next_pc.
  task automatic fetch_word(input logic [31:0] next_pc, input logic [31:0] data);
    i_imem_gnt = 1'b1;
    cyc();
    i_imem_gnt    = 1'b0;
    i_pc          = next_pc;
    i_imem_rvalid = 1'b1;
    i_imem_rdata  = data;
    cyc();
    i_imem_rvalid = 1'b0;
  endtask

  initial begin
`ifdef FETCH_ERR_EN
    i_imem_err = 1'b0;
`endif
    // Reset state
    reset_dut(32'h80);
    i_resetn = 1'b0;
    #1;
    check_val("rst_req",   o_imem_req,    0);
    check_val("rst_pc_we", o_pc_we,       0);
    check_val("rst_valid", o_instr_valid, 0);
    check_val("rst_instr", o_instr,       0);
    check_val("rst_ipc",   o_instr_pc,    0);
    i_resetn = 1'b1;

    // Basic fetch at 0x80
    i_instr_ready = 1'b1;
    cyc();
    check_val("t1_req",  o_imem_req,  1);
    check_val("t1_addr", o_imem_addr, 32'h80);
    check_val("t1_we0",  o_pc_we,     0);
    i_imem_gnt = 1'b1;
    #1;
    check_val("t1_we1", o_pc_we, 1);
    cyc();
    i_imem_gnt    = 1'b0;
    i_pc          = 32'h84;
    i_imem_rvalid = 1'b1;
    i_imem_rdata  = 32'h13;
    #1;
    check_val("t1_we_pulse", o_pc_we,       0);
    check_val("t1_nvalid",   o_instr_valid, 0);
    cyc();
    i_imem_rvalid = 1'b0;
    #1;
    check_val("t1_valid", o_instr_valid, 1);
    check_val("t1_instr", o_instr,       32'h13);
    check_val("t1_ipc",   o_instr_pc,    32'h80);

    // Grant withheld for 5 cycles at 0x84
    for (int i = 0; i < 5; i++) begin
      cyc();
      check_val("t3_req",  o_imem_req,  1);
      check_val("t3_addr", o_imem_addr, 32'h84);
      check_val("t3_we",   o_pc_we,     0);
    end
    check_val("t3_popped", o_instr_valid, 0);
    i_instr_ready = 1'b0;
    i_imem_gnt    = 1'b1;
    #1;
    check_val("t3_we_gnt", o_pc_we, 1);

    // Flush in WAIT, stale 0xDEADBEEF dropped, refetch from 0x200
    cyc();
    i_imem_gnt = 1'b0;
    i_pc       = 32'h200;
    i_flush    = 1'b1;
    #1;
    check_val("t4_we_fl", o_pc_we, 0);
    cyc();
    i_flush = 1'b0;
    #1;
    check_val("t4_drain_req", o_imem_req, 0);
    i_imem_rvalid = 1'b1;
    i_imem_rdata  = 32'hDEADBEEF;
    cyc();
    i_imem_rvalid = 1'b0;
    #1;
    check_val("t4_valid", o_instr_valid, 0);
    check_val("t4_idle",  o_imem_req,    0);
    cyc();
    check_val("t4_req",    o_imem_req,    1);
    check_val("t4_addr",   o_imem_addr,   32'h200);
    check_val("t4_valid2", o_instr_valid, 0);

    // Fill the FIFO with ready low, then one pop restarts fetching
    reset_dut(32'h80);
    cyc();
    fetch_word(32'h84, 32'h11111111);
    #1;
    check_val("t2_req1",   o_imem_req,  1);
    check_val("t2_addr1",  o_imem_addr, 32'h84);
    check_val("t2_instr1", o_instr,     32'h11111111);
    fetch_word(32'h88, 32'h22222222);
    #1;
    check_val("t2_full_req", o_imem_req, 0);
    check_val("t2_head",     o_instr,    32'h11111111);
    check_val("t2_head_pc",  o_instr_pc, 32'h80);
    cyc();
    cyc();
    check_val("t2_stall_req", o_imem_req, 0);
    check_val("t2_hold",      o_instr,    32'h11111111);
    i_instr_ready = 1'b1;
    cyc();
    i_instr_ready = 1'b0;
    #1;
    check_val("t2_valid2", o_instr_valid, 1);
    check_val("t2_instr2", o_instr,       32'h22222222);
    check_val("t2_ipc2",   o_instr_pc,    32'h84);
    cyc();
    check_val("t2_req88",  o_imem_req,  1);
    check_val("t2_addr88", o_imem_addr, 32'h88);

    // Flush coinciding with rvalid: data not pushed
    i_imem_gnt = 1'b1;
    cyc();
    i_imem_gnt    = 1'b0;
    i_pc          = 32'h300;
    i_imem_rvalid = 1'b1;
    i_imem_rdata  = 32'hBAD0BAD0;
    i_flush       = 1'b1;
    #1;
    check_val("t5_we_fl", o_pc_we, 0);
    cyc();
    i_imem_rvalid = 1'b0;
    i_flush       = 1'b0;
    #1;
    check_val("t5_valid", o_instr_valid, 0);
    check_val("t5_idle",  o_imem_req,    0);
    cyc();
    check_val("t5_req",    o_imem_req,    1);
    check_val("t5_addr",   o_imem_addr,   32'h300);
    check_val("t5_valid2", o_instr_valid, 0);

    // Push and pop together at count 1, eight times across pointer wrap
    fetch_word(32'h304, 32'hA0000000);
    for (int k = 1; k <= 8; k++) begin
      i_imem_gnt = 1'b1;
      cyc();
      i_imem_gnt    = 1'b0;
      i_pc          = 32'h300 + 32'(4 * (k + 1));
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = 32'hA0000000 + 32'(k);
      i_instr_ready = 1'b1;
      cyc();
      i_imem_rvalid = 1'b0;
      i_instr_ready = 1'b0;
      #1;
      check_val("t5_wr_valid", o_instr_valid, 1);
      check_val("t5_wr_instr", o_instr,       32'hA0000000 + 32'(k));
      check_val("t5_wr_ipc",   o_instr_pc,    32'h300 + 32'(4 * k));
      check_val("t5_wr_addr",  o_imem_addr,   32'h300 + 32'(4 * (k + 1)));
    end
    i_instr_ready = 1'b1;
    cyc();
    i_instr_ready = 1'b0;
    #1;
    check_val("t5_cnt1_empty", o_instr_valid, 0);

`ifdef FETCH_ERR_EN
    // Bus error travels with its entry
    reset_dut(32'h90);
    cyc();
    i_imem_err = 1'b1;
    fetch_word(32'h94, 32'h0BADF00D);
    i_imem_err = 1'b0;
    #1;
    check_val("t6_err1", o_instr_err, 1);
    check_val("t6_pc1",  o_instr_pc,  32'h90);
    fetch_word(32'h98, 32'h00000013);
    i_instr_ready = 1'b1;
    cyc();
    i_instr_ready = 1'b0;
    #1;
    check_val("t6_err2", o_instr_err, 0);
    check_val("t6_pc2",  o_instr_pc,  32'h94);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
